datamux_rr: RTL

- Parametrised successor of the fixed six-source FTDI data multiplexer.
- Merges NUM_CH single-clock FWFT-less FIFO read ports into one DATA_W-wide sink write port (FTDI FIFO side), using a rotating-priority (round-robin) arbiter.
- Adds configurable burst length per grant, sink back-pressure via almost_full, per-channel enable masking and an observable grant index.
- Sits between the per-source data concentrators and the FTDI/USB write interface.

---
 rtl/datamux_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/datamux_rr.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/datamux_pkg.sv
// Shared types and helpers for the round-robin data multiplexer family.
package datamux_pkg;

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    localparam int unsigned DATA_W_DEF    = 64;
    localparam int unsigned MAX_BURST_DEF = 4;

    // Successor index with wrap-around at n.
    function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
        return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter: grants the first requester strictly after token.
module rr_arbiter
    import datamux_pkg::*;
#(
    parameter int unsigned NUM_CH = 6,
    parameter int unsigned CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   token,
    output logic [NUM_CH-1:0] gnt,
    output logic [CH_W-1:0]   gnt_idx,
    output logic              gnt_valid
);

    int unsigned idx;

    always_comb begin
        gnt       = '0;
        gnt_idx   = token;
        gnt_valid = 1'b0;
        idx       = 32'(token);
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            idx = next_idx(idx, NUM_CH);
            if (!gnt_valid && req[CH_W'(idx)]) begin
                gnt_valid           = 1'b1;
                gnt_idx             = CH_W'(idx);
                gnt[CH_W'(idx)]     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/datamux_rr.sv
// Round-robin merge of NUM_CH standard-read FIFOs into one sink with per-grant bursts.
// Optional statistics counters are built when DATAMUX_RR_STATS_EN is defined.
module datamux_rr
    import datamux_pkg::*;
#(
    parameter int unsigned NUM_CH    = 6,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned MAX_BURST = MAX_BURST_DEF,
    parameter int unsigned CH_W      = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [NUM_CH-1:0]        ch_enable,
    input  logic [NUM_CH-1:0]        ch_empty,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic [NUM_CH-1:0]        ch_rd_en,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_wr_en,
    input  logic                     out_full,
    input  logic                     out_almost_full,
    output logic [CH_W-1:0]          grant_id,
    output logic                     busy
`ifdef DATAMUX_RR_STATS_EN
    ,
    input  logic                     stats_clr,
    output logic [NUM_CH*32-1:0]     ch_word_cnt,
    output logic [31:0]              stall_cnt
`endif
);

    localparam logic [7:0] BURST_LIM = 8'(MAX_BURST);

    state_t            state;
    logic [CH_W-1:0]   grant_q;
    logic [7:0]        burst_cnt;
    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] arb_gnt;
    logic [CH_W-1:0]   arb_idx;
    logic              arb_valid;
    logic              rd_ok;
    logic              rd_start;
    logic              rd_more;
    logic [DATA_W-1:0] sel_data;

    assign req   = ~ch_empty & ch_enable & {NUM_CH{enable}};
    assign rd_ok = !out_full && !out_almost_full;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_arb (
        .req       (req),
        .token     (grant_q),
        .gnt       (arb_gnt),
        .gnt_idx   (arb_idx),
        .gnt_valid (arb_valid)
    );

    // Read strobes are combinational so the FIFO word lands in the very next cycle.
    always_comb begin
        rd_start = !rst && (state == IDLE) && arb_valid && rd_ok;
        rd_more  = !rst && (state == BURST) && req[grant_q] && (burst_cnt < BURST_LIM) && rd_ok;
        ch_rd_en = '0;
        if (rd_start) begin
            ch_rd_en = arb_gnt;
        end else if (rd_more) begin
            ch_rd_en[grant_q] = 1'b1;
        end
    end

    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (grant_q == CH_W'(i)) begin
                sel_data = ch_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // BURST is entered or held only when a read was issued, so it marks a word in flight.
    assign busy      = (state == BURST);
    assign out_wr_en = busy && !rst;
    assign out_data  = out_wr_en ? sel_data : '0;
    assign grant_id  = grant_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            grant_q   <= CH_W'(NUM_CH - 1);
            burst_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rd_start) begin
                        grant_q   <= arb_idx;
                        burst_cnt <= 8'd1;
                        state     <= BURST;
                    end
                end
                BURST: begin
                    if (rd_more) begin
                        burst_cnt <= burst_cnt + 8'd1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DATAMUX_RR_STATS_EN
    logic [31:0] word_cnt [NUM_CH];

    always_ff @(posedge clk) begin
        if (rst || stats_clr) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                word_cnt[i] <= '0;
            end
            stall_cnt <= '0;
        end else begin
            if (out_wr_en && (word_cnt[grant_q] != '1)) begin
                word_cnt[grant_q] <= word_cnt[grant_q] + 32'd1;
            end
            if ((|req) && !rd_ok && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end

    always_comb begin
        ch_word_cnt = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            ch_word_cnt[i*32 +: 32] = word_cnt[i];
        end
    end
`endif

endmodule
